// File: rtl/rfm_tracker_mb.sv
// rfm_tracker_mb: per-bank Misra-Gries activation tracker issuing NRR on RFM, with RAA-based RFM requests; TABLE_RD_EN adds a registered table read port
module rfm_tracker_mb #(
  parameter int NUM_BANK       = 4,
  parameter int BANK_BITS      = 2,
  parameter int NUM_ENTRY      = 16,
  parameter int NUM_ENTRY_BITS = 4,
  parameter int ADDR_SIZE      = 18,
  parameter int CNT_SIZE       = 16,
  parameter int RFM_TH         = 8
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef TABLE_RD_EN
  input  logic [BANK_BITS-1:0]      dbg_bank,
  input  logic [NUM_ENTRY_BITS-1:0] dbg_idx,
  output logic                      dbg_valid,
  output logic [ADDR_SIZE-1:0]      dbg_addr,
  output logic [CNT_SIZE-1:0]       dbg_cnt,
  output logic [CNT_SIZE-1:0]       dbg_spcnt,
`endif
  input  logic                      act_cmd,
  input  logic [BANK_BITS-1:0]      act_bank,
  input  logic [ADDR_SIZE-1:0]      act_addr,
  input  logic                      rfm_cmd,
  input  logic [BANK_BITS-1:0]      rfm_bank,
  output logic                      cmd_ready,
  output logic                      nrr_cmd,
  output logic [BANK_BITS-1:0]      nrr_bank,
  output logic [ADDR_SIZE-1:0]      nrr_addr,
  output logic [NUM_BANK-1:0]       rfm_req
);
  typedef enum logic [1:0] {IDLE, ACT_UPD, RFM_SCAN, RFM_ISSUE} state_t;
  typedef logic [CNT_SIZE-1:0] cnt_t;
  typedef logic [NUM_ENTRY_BITS-1:0] idx_t;
  localparam cnt_t TH = cnt_t'(RFM_TH);
  function automatic cnt_t inc(cnt_t x);
    return &x ? x : x + 1'b1;
  endfunction
  state_t state_q, state_d;
  logic [BANK_BITS-1:0] bank_q;
  logic [ADDR_SIZE-1:0] addr_q;
  idx_t sel_q, hit_idx, free_idx, best;
  logic found_q, hit, free, found;
  cnt_t best_cnt;
  logic [NUM_BANK-1:0] req_d;
  logic [NUM_BANK-1:0][NUM_ENTRY-1:0] vld;
  logic [NUM_BANK-1:0][NUM_ENTRY-1:0][ADDR_SIZE-1:0] ent_addr;
  logic [NUM_BANK-1:0][NUM_ENTRY-1:0][CNT_SIZE-1:0] ent_cnt;
  logic [NUM_BANK-1:0][CNT_SIZE-1:0] spcnt, raa;
  assign cmd_ready = state_q == IDLE;
  assign nrr_cmd = state_q == RFM_ISSUE && found_q;
  // next state: RFM wins over ACT in IDLE, every other state is a fixed step
  always_comb begin
    state_d = state_q == IDLE ? (rfm_cmd ? RFM_SCAN : act_cmd ? ACT_UPD : IDLE) :
              state_q == RFM_SCAN ? RFM_ISSUE : IDLE;
  end
  // ACT lookup: descending walk so the lowest matching/replaceable index wins
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    free = 1'b0;
    free_idx = '0;
    for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
      if (vld[bank_q][i] && ent_addr[bank_q][i] == addr_q) begin
        hit = 1'b1;
        hit_idx = idx_t'(i);
      end
      if (!vld[bank_q][i] || ent_cnt[bank_q][i] == spcnt[bank_q]) begin
        free = 1'b1;
        free_idx = idx_t'(i);
      end
    end
  end
  // RFM scan: hottest valid entry, strict compare keeps ties on the lowest index
  always_comb begin
    found = 1'b0;
    best = '0;
    best_cnt = '0;
    for (int i = 0; i < NUM_ENTRY; i++) begin
      if (vld[bank_q][i] && (!found || ent_cnt[bank_q][i] > best_cnt)) begin
        found = 1'b1;
        best = idx_t'(i);
        best_cnt = ent_cnt[bank_q][i];
      end
    end
  end
  // request level per bank, registered below
  always_comb begin
    req_d = '0;
    for (int b = 0; b < NUM_BANK; b++) req_d[b] = raa[b] >= TH;
  end
  // control path: command capture, scan result and NRR target registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bank_q <= '0;
      addr_q <= '0;
      sel_q <= '0;
      found_q <= 1'b0;
      nrr_bank <= '0;
      nrr_addr <= '0;
      rfm_req <= '0;
    end else begin
      state_q <= state_d;
      rfm_req <= req_d;
      if (state_q == IDLE) begin
        bank_q <= rfm_cmd ? rfm_bank : act_bank;
        addr_q <= act_addr;
      end
      if (state_q == RFM_SCAN) begin
        sel_q <= best;
        found_q <= found;
        if (found) begin
          nrr_bank <= bank_q;
          nrr_addr <= ent_addr[bank_q][best];
        end
      end
    end
  end
  // table, spillover and RAA updates on ACT_UPD and RFM_ISSUE
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      ent_addr <= '0;
      ent_cnt <= '0;
      spcnt <= '0;
      raa <= '0;
    end else if (state_q == ACT_UPD) begin
      raa[bank_q] <= inc(raa[bank_q]);
      if (hit) ent_cnt[bank_q][hit_idx] <= inc(ent_cnt[bank_q][hit_idx]);
      else if (free) begin
        vld[bank_q][free_idx] <= 1'b1;
        ent_addr[bank_q][free_idx] <= addr_q;
        ent_cnt[bank_q][free_idx] <= inc(spcnt[bank_q]);
      end else spcnt[bank_q] <= inc(spcnt[bank_q]);
    end else if (state_q == RFM_ISSUE) begin
      if (found_q) ent_cnt[bank_q][sel_q] <= spcnt[bank_q];
      raa[bank_q] <= raa[bank_q] >= TH ? raa[bank_q] - TH : '0;
    end
  end
`ifdef TABLE_RD_EN
  // debug read: one-cycle registered, returns pre-write contents on collision
  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_valid <= 1'b0;
      dbg_addr <= '0;
      dbg_cnt <= '0;
      dbg_spcnt <= '0;
    end else begin
      dbg_valid <= vld[dbg_bank][dbg_idx];
      dbg_addr <= ent_addr[dbg_bank][dbg_idx];
      dbg_cnt <= ent_cnt[dbg_bank][dbg_idx];
      dbg_spcnt <= spcnt[dbg_bank];
    end
  end
`endif
endmodule

// File: tb/tb_rfm_tracker_mb.sv
// tb_rfm_tracker_mb: randomized scoreboard bench against a rule-level tracker model
module tb_rfm_tracker_mb;
  localparam int NB = 4, BB = 2, NE = 4, EB = 2, AW = 18, CW = 8, TH = 4, MAXC = 255;
  logic clk = 0, rst = 1, act_cmd = 0, rfm_cmd = 0;
  logic [BB-1:0] act_bank = '0, rfm_bank = '0;
  logic [AW-1:0] act_addr = '0;
  logic cmd_ready, nrr_cmd;
  logic [BB-1:0] nrr_bank;
  logic [AW-1:0] nrr_addr;
  logic [NB-1:0] rfm_req;
  rfm_tracker_mb #(.NUM_BANK(NB), .BANK_BITS(BB), .NUM_ENTRY(NE), .NUM_ENTRY_BITS(EB),
                   .ADDR_SIZE(AW), .CNT_SIZE(CW), .RFM_TH(TH)) dut (
    .clk(clk), .rst(rst), .act_cmd(act_cmd), .act_bank(act_bank), .act_addr(act_addr),
    .rfm_cmd(rfm_cmd), .rfm_bank(rfm_bank), .cmd_ready(cmd_ready), .nrr_cmd(nrr_cmd),
    .nrr_bank(nrr_bank), .nrr_addr(nrr_addr), .rfm_req(rfm_req));
  always #5 clk = ~clk;
  typedef struct packed {logic [BB-1:0] b; logic [AW-1:0] a;} nrr_t;
  nrr_t exp_q[$];
  int n_chk = 0, n_pass = 0;
  int m_vld[NB][NE], m_addr[NB][NE], m_cnt[NB][NE], m_sp[NB], m_raa[NB];
  function automatic void check(string name, longint got, longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endfunction
  function automatic int sat(int x);
    return x > MAXC ? MAXC : x;
  endfunction
  function automatic void m_reset();
    for (int b = 0; b < NB; b++) begin
      m_sp[b] = 0;
      m_raa[b] = 0;
      for (int j = 0; j < NE; j++) begin
        m_vld[b][j] = 0; m_addr[b][j] = 0; m_cnt[b][j] = 0;
      end
    end
  endfunction
  function automatic void m_act(int b, int a);
    m_raa[b] = sat(m_raa[b] + 1);
    for (int j = 0; j < NE; j++)
      if (m_vld[b][j] != 0 && m_addr[b][j] == a) begin
        m_cnt[b][j] = sat(m_cnt[b][j] + 1);
        return;
      end
    for (int j = 0; j < NE; j++)
      if (m_vld[b][j] == 0 || m_cnt[b][j] == m_sp[b]) begin
        m_vld[b][j] = 1; m_addr[b][j] = a; m_cnt[b][j] = sat(m_sp[b] + 1);
        return;
      end
    m_sp[b] = sat(m_sp[b] + 1);
  endfunction
  function automatic void m_rfm(int b);
    int best = -1;
    for (int j = 0; j < NE; j++)
      if (m_vld[b][j] != 0 && (best < 0 || m_cnt[b][j] > m_cnt[b][best])) best = j;
    if (best >= 0) begin
      exp_q.push_back({BB'(b), AW'(m_addr[b][best])});
      m_cnt[b][best] = m_sp[b];
    end
    m_raa[b] = m_raa[b] >= TH ? m_raa[b] - TH : 0;
  endfunction
  function automatic logic [NB-1:0] m_req();
    logic [NB-1:0] r = '0;
    for (int b = 0; b < NB; b++) r[b] = m_raa[b] >= TH;
    return r;
  endfunction
  logic prev_nrr = 0;
  always @(negedge clk) begin
    if (nrr_cmd) begin
      nrr_t e;
      check("nrr_width", prev_nrr, 0);
      check("nrr_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("nrr_bank", nrr_bank, e.b);
        check("nrr_addr", nrr_addr, e.a);
      end
    end
    prev_nrr = nrr_cmd;
  end
  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", cmd_ready, 1);
  endtask
  task automatic cmd(bit a_en, bit r_en, int ab, int aa, int rb);
    int n;
    @(posedge clk);
    @(negedge clk);
    wait_ready();
    check("rfm_req", rfm_req, m_req());
    act_cmd = a_en; act_bank = BB'(ab); act_addr = AW'(aa);
    rfm_cmd = r_en; rfm_bank = BB'(rb);
    if (r_en) m_rfm(rb);
    else if (a_en) m_act(ab, aa);
    @(posedge clk);
    #1;
    act_cmd = 0; rfm_cmd = 0;
    n = 1;
    while (!cmd_ready && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(r_en ? "rfm_latency" : "act_latency", n, r_en ? 3 : 2);
    if (r_en) check("nrr_done", exp_q.size(), 0);
  endtask
  initial begin
    m_reset();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_ready", cmd_ready, 1);
    check("rst_nrr", nrr_cmd, 0);
    check("rst_bank", nrr_bank, 0);
    check("rst_addr", nrr_addr, 0);
    check("rst_req", rfm_req, 0);
    cmd(0, 1, 0, 0, 3);
    repeat (5) cmd(1, 0, 2, 7, 0);
    repeat (2) cmd(1, 0, 2, 9, 0);
    cmd(0, 1, 0, 0, 2);
    cmd(1, 1, 1, 42, 0);
    cmd(1, 0, 1, 42, 0);
    cmd(0, 1, 0, 0, 1);
    repeat (300) cmd(1, 0, 3, 1000, 0);
    repeat (260) cmd(1, 0, 3, 2000, 0);
    cmd(0, 1, 0, 0, 3);
    cmd(0, 1, 0, 0, 3);
    for (int k = 0; k < 400; k++) begin
      int r = $urandom_range(0, 99);
      int b = $urandom_range(0, NB - 1);
      int a = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 2**AW - 1)) : int'($urandom_range(0, 7));
      cmd(r < 30, r < 5 || r >= 70, b, a, $urandom_range(0, NB - 1));
    end
    repeat (6) cmd(1, 0, 1, 55, 0);
    @(posedge clk);
    @(negedge clk);
    wait_ready();
    rfm_cmd = 1; rfm_bank = 1;
    @(posedge clk);
    #1 rfm_cmd = 0; rst = 1;
    @(posedge clk);
    #1 rst = 0;
    m_reset();
    @(negedge clk);
    check("abort_ready", cmd_ready, 1);
    check("abort_req", rfm_req, 0);
    cmd(0, 1, 0, 0, 1);
    repeat (2) cmd(1, 0, 1, 77, 0);
    cmd(1, 0, 1, 78, 0);
    cmd(0, 1, 0, 0, 1);
    repeat (4) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
